// File: rtl/retro_cache_fill_controller.sv
// retro_cache_fill_controller
// ---------------------------------------------------------------------------
// Miss sequencer and cache-port owner for the one-cycle cartridge cache.
// In IDLE, core reads pass straight through to the cache port. A read miss
// raises o_Delay in the same cycle. The block then requests one aligned cache
// line from backing memory and writes every returned byte into the cache.
// One settle cycle (DONE) follows before the core is released to retry.
//
// Ports:
//   i_Clk, i_Reset_n          clock, synchronous active-low reset
//   i_CoreAccess/Address/Bank core read strobe, address, current bank number
//   o_Delay                   stall request to the CCCU
//   o_CoreDout                read data to core (= i_CacheDin)
//   o_CacheAccess/Write/Address/Dout, i_CacheDin, i_CacheDataReady
//                             cache port (address = {bank, core address})
//   o_MemReq, o_MemAddress, i_MemAck, i_MemValid, i_MemData
//                             backing-memory line request and fill beats
//   o_MissCount, o_FillCycles saturating statistics counters, present only
//                             when RETRO_CACHE_FILL_STATS_EN is defined
//
// Optional feature macro: RETRO_CACHE_FILL_STATS_EN
// ---------------------------------------------------------------------------
module retro_cache_fill_controller #(
    parameter int CoreAddressWidth = 16,
    parameter int BankBits         = 4,
    parameter int DataBusWidth     = 8,
    parameter int CacheLineBits    = 7
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Reset_n,
    input  logic                                 i_CoreAccess,
    input  logic [CoreAddressWidth-1:0]          i_CoreAddress,
    input  logic [BankBits-1:0]                  i_Bank,
    output logic                                 o_Delay,
    output logic [DataBusWidth-1:0]              o_CoreDout,
    output logic                                 o_CacheAccess,
    output logic                                 o_CacheWrite,
    output logic [BankBits+CoreAddressWidth-1:0] o_CacheAddress,
    output logic [DataBusWidth-1:0]              o_CacheDout,
    input  logic [DataBusWidth-1:0]              i_CacheDin,
    input  logic                                 i_CacheDataReady,
    output logic                                 o_MemReq,
    output logic [BankBits+CoreAddressWidth-1:0] o_MemAddress,
    input  logic                                 i_MemAck,
    input  logic                                 i_MemValid,
    input  logic [DataBusWidth-1:0]              i_MemData
`ifdef RETRO_CACHE_FILL_STATS_EN
    ,
    output logic [31:0]                          o_MissCount,
    output logic [31:0]                          o_FillCycles
`endif
);

    localparam int FAW = BankBits + CoreAddressWidth;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQUEST = 2'd1;
    localparam logic [1:0] FILL    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]                 r_state;
    // Only the line-number bits of the base are stored; offset bits are zero.
    logic [FAW-CacheLineBits-1:0] r_base_hi;
    logic [CacheLineBits-1:0]   r_count;
    logic                       r_mem_req;
    logic [FAW-1:0]             r_mem_addr;

    logic [FAW-1:0]             w_full_addr;
    logic [FAW-1:0]             w_line_base;
    logic [FAW-1:0]             w_fill_addr;
    logic                       w_miss;
    logic                       w_last_beat;

    assign w_full_addr = {i_Bank, i_CoreAddress};
    assign w_line_base = {w_full_addr[FAW-1:CacheLineBits], {CacheLineBits{1'b0}}};
    assign w_fill_addr = {r_base_hi, r_count};
    assign w_miss      = i_CoreAccess & ~i_CacheDataReady;
    assign w_last_beat = (r_count == {CacheLineBits{1'b1}});

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_state    <= IDLE;
            r_base_hi  <= '0;
            r_count    <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_base_hi  <= w_full_addr[FAW-1:CacheLineBits];
                        r_mem_addr <= w_line_base;
                        r_mem_req  <= 1'b1;
                        r_state    <= REQUEST;
                    end
                end
                REQUEST: begin
                    // Beats arriving before the ack are not part of this line.
                    if (i_MemAck) begin
                        r_mem_req <= 1'b0;
                        r_count   <= '0;
                        r_state   <= FILL;
                    end
                end
                FILL: begin
                    if (i_MemValid) begin
                        r_count <= r_count + {{(CacheLineBits-1){1'b0}}, 1'b1};
                        if (w_last_beat) begin
                            r_state <= DONE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_Delay        = 1'b1;
        o_CacheAccess  = 1'b0;
        o_CacheWrite   = 1'b0;
        o_CacheAddress = w_fill_addr;
        case (r_state)
            IDLE: begin
                o_Delay        = w_miss;
                o_CacheAccess  = i_CoreAccess;
                o_CacheAddress = w_full_addr;
            end
            FILL: begin
                o_CacheAccess = i_MemValid;
                o_CacheWrite  = i_MemValid;
            end
            default: begin
            end
        endcase
    end

    assign o_CoreDout   = i_CacheDin;
    assign o_CacheDout  = i_MemData;
    assign o_MemReq     = r_mem_req;
    assign o_MemAddress = r_mem_addr;

`ifdef RETRO_CACHE_FILL_STATS_EN
    logic [31:0] r_miss_count;
    logic [31:0] r_fill_cycles;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_miss_count  <= '0;
            r_fill_cycles <= '0;
        end else begin
            if ((r_state == IDLE) && w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
            if ((r_state != IDLE) && (r_fill_cycles != 32'hFFFF_FFFF)) begin
                r_fill_cycles <= r_fill_cycles + 32'd1;
            end
        end
    end

    assign o_MissCount  = r_miss_count;
    assign o_FillCycles = r_fill_cycles;
`endif

endmodule

// File: tb/tb_retro_cache_fill_controller.sv
// tb_retro_cache_fill_controller
// Directed-step bench for retro_cache_fill_controller: hit pass-through,
// full fill, gapped fill, late ack with stray beats, reset mid-fill, and
// (when RETRO_CACHE_FILL_STATS_EN is defined) the statistics counters.
module tb_retro_cache_fill_controller;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n;
    logic        i_CoreAccess;
    logic [15:0] i_CoreAddress;
    logic [3:0]  i_Bank;
    logic        o_Delay;
    logic [7:0]  o_CoreDout;
    logic        o_CacheAccess;
    logic        o_CacheWrite;
    logic [19:0] o_CacheAddress;
    logic [7:0]  o_CacheDout;
    logic [7:0]  i_CacheDin;
    logic        i_CacheDataReady;
    logic        o_MemReq;
    logic [19:0] o_MemAddress;
    logic        i_MemAck;
    logic        i_MemValid;
    logic [7:0]  i_MemData;
`ifdef RETRO_CACHE_FILL_STATS_EN
    logic [31:0] o_MissCount;
    logic [31:0] o_FillCycles;
`endif

    int errors = 0;
    int checks = 0;
    int dut_writes;

    always #5 i_Clk = ~i_Clk;

    retro_cache_fill_controller dut (
        .i_Clk           (i_Clk),
        .i_Reset_n       (i_Reset_n),
        .i_CoreAccess    (i_CoreAccess),
        .i_CoreAddress   (i_CoreAddress),
        .i_Bank          (i_Bank),
        .o_Delay         (o_Delay),
        .o_CoreDout      (o_CoreDout),
        .o_CacheAccess   (o_CacheAccess),
        .o_CacheWrite    (o_CacheWrite),
        .o_CacheAddress  (o_CacheAddress),
        .o_CacheDout     (o_CacheDout),
        .i_CacheDin      (i_CacheDin),
        .i_CacheDataReady(i_CacheDataReady),
        .o_MemReq        (o_MemReq),
        .o_MemAddress    (o_MemAddress),
        .i_MemAck        (i_MemAck),
        .i_MemValid      (i_MemValid),
        .i_MemData       (i_MemData)
`ifdef RETRO_CACHE_FILL_STATS_EN
        ,
        .o_MissCount     (o_MissCount),
        .o_FillCycles    (o_FillCycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] miss_exp, input logic [31:0] fill_exp);
`ifdef RETRO_CACHE_FILL_STATS_EN
        chk({tag, "_miss_count"}, o_MissCount, miss_exp);
        chk({tag, "_fill_cycles"}, o_FillCycles, fill_exp);
`else
        if (tag.len() == 0) $display("unused %0d %0d", miss_exp, fill_exp);
`endif
    endtask

    initial begin
        i_Reset_n        = 1'b0;
        i_CoreAccess     = 1'b0;
        i_CoreAddress    = 16'h0000;
        i_Bank           = 4'h0;
        i_CacheDin       = 8'h00;
        i_CacheDataReady = 1'b0;
        i_MemAck         = 1'b0;
        i_MemValid       = 1'b0;
        i_MemData        = 8'h00;

        // ---- reset ----
        repeat (3) @(negedge i_Clk);
        #1;
        chk("rst_memreq", {31'd0, o_MemReq}, 32'd0);
        chk("rst_memaddr", {12'd0, o_MemAddress}, 32'd0);
        chk("rst_delay", {31'd0, o_Delay}, 32'd0);
        chk("rst_cacheaccess", {31'd0, o_CacheAccess}, 32'd0);
        chk("rst_cachewrite", {31'd0, o_CacheWrite}, 32'd0);
        chk_stats("rst", 32'd0, 32'd0);
        $display("step reset done");

        // ---- hit ----
        @(negedge i_Clk);
        i_Reset_n = 1'b1;
        i_CoreAccess = 1'b1; i_CoreAddress = 16'h1234; i_Bank = 4'h2;
        i_CacheDataReady = 1'b1; i_CacheDin = 8'h5A;
        #1;
        chk("hit_delay", {31'd0, o_Delay}, 32'd0);
        chk("hit_cacheaddr", {12'd0, o_CacheAddress}, 32'h21234);
        chk("hit_cacheaccess", {31'd0, o_CacheAccess}, 32'd1);
        chk("hit_cachewrite", {31'd0, o_CacheWrite}, 32'd0);
        chk("hit_coredout", {24'd0, o_CoreDout}, 32'h5A);
        repeat (3) begin
            @(negedge i_Clk); #1;
            chk("hit_memreq", {31'd0, o_MemReq}, 32'd0);
            chk("hit_delay_hold", {31'd0, o_Delay}, 32'd0);
        end
        $display("step hit done");

        // ---- miss and full fill ----
        @(negedge i_Clk);
        i_CoreAddress = 16'h12B5; i_Bank = 4'h1; i_CacheDataReady = 1'b0;
        #1;
        chk("miss_delay_same_cycle", {31'd0, o_Delay}, 32'd1);
        chk("miss_cacheaddr", {12'd0, o_CacheAddress}, 32'h112B5);
        repeat (2) begin
            @(negedge i_Clk); #1;
            chk("req_memreq", {31'd0, o_MemReq}, 32'd1);
            chk("req_memaddr", {12'd0, o_MemAddress}, 32'h11280);
            chk("req_delay", {31'd0, o_Delay}, 32'd1);
            chk("req_cacheaccess", {31'd0, o_CacheAccess}, 32'd0);
        end
        @(negedge i_Clk);
        i_MemAck = 1'b1;
        #1;
        chk("ack_memreq", {31'd0, o_MemReq}, 32'd1);
        for (int i = 0; i < 128; i++) begin
            @(negedge i_Clk);
            i_MemAck = 1'b0; i_MemValid = 1'b1; i_MemData = 8'(i);
            #1;
            if (i == 0) chk("fill_memreq_dropped", {31'd0, o_MemReq}, 32'd0);
            chk("fill_write", {31'd0, o_CacheWrite}, 32'd1);
            chk("fill_addr", {12'd0, o_CacheAddress}, 32'h11280 + 32'(i));
            chk("fill_data", {24'd0, o_CacheDout}, 32'(i));
            chk("fill_delay", {31'd0, o_Delay}, 32'd1);
        end
        @(negedge i_Clk);
        i_MemData = 8'hFF;   // excess beat in DONE must be dropped
        #1;
        chk("done_access", {31'd0, o_CacheAccess}, 32'd0);
        chk("done_write", {31'd0, o_CacheWrite}, 32'd0);
        chk("done_delay", {31'd0, o_Delay}, 32'd1);
        @(negedge i_Clk);
        i_CacheDataReady = 1'b1;
        #1;
        chk("retry_delay", {31'd0, o_Delay}, 32'd0);
        chk("retry_write", {31'd0, o_CacheWrite}, 32'd0);
        chk("retry_memreq", {31'd0, o_MemReq}, 32'd0);
        chk_stats("fill1", 32'd1, 32'd132);
        $display("step miss/fill done");

        // ---- gapped fill ----
        @(negedge i_Clk);
        i_MemValid = 1'b0;
        i_CoreAddress = 16'h4000; i_Bank = 4'h3; i_CacheDataReady = 1'b0;
        #1;
        chk("gap_miss_delay", {31'd0, o_Delay}, 32'd1);
        @(negedge i_Clk);
        i_MemAck = 1'b1;
        #1;
        chk("gap_memaddr", {12'd0, o_MemAddress}, 32'h34000);
        dut_writes = 0;
        for (int c = 0; c < 400 && dut_writes < 128; c++) begin
            @(negedge i_Clk);
            i_MemAck = 1'b0;
            i_MemValid = ((c % 3) == 0);
            i_MemData = 8'(dut_writes);
            #1;
            chk("gap_write_follows_valid", {31'd0, o_CacheWrite}, {31'd0, i_MemValid});
            if (o_CacheWrite) begin
                chk("gap_addr", {12'd0, o_CacheAddress}, 32'h34000 + 32'(dut_writes));
                dut_writes++;
            end
        end
        chk("gap_write_count", 32'(dut_writes), 32'd128);
        @(negedge i_Clk);
        i_MemValid = 1'b1;
        #1;
        chk("gap_done_write", {31'd0, o_CacheWrite}, 32'd0);
        chk("gap_done_delay", {31'd0, o_Delay}, 32'd1);
        @(negedge i_Clk);
        i_MemValid = 1'b0; i_CacheDataReady = 1'b1;
        #1;
        chk("gap_retry_delay", {31'd0, o_Delay}, 32'd0);
        chk_stats("fill2", 32'd2, 32'd516);
        $display("step gapped fill done");

        // ---- late ack with stray beats and address change ----
        @(negedge i_Clk);
        i_CoreAddress = 16'h0081; i_Bank = 4'h0; i_CacheDataReady = 1'b0;
        #1;
        chk("late_miss_delay", {31'd0, o_Delay}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge i_Clk);
            i_MemValid = k[0];
            if (k == 3) begin
                i_CoreAddress = 16'h7777;
                i_Bank = 4'h9;
            end
            #1;
            chk("late_no_write", {31'd0, o_CacheWrite}, 32'd0);
            chk("late_no_access", {31'd0, o_CacheAccess}, 32'd0);
            chk("late_memaddr_stable", {12'd0, o_MemAddress}, 32'h00080);
            chk("late_memreq", {31'd0, o_MemReq}, 32'd1);
            chk("late_delay", {31'd0, o_Delay}, 32'd1);
        end
        @(negedge i_Clk);
        i_MemAck = 1'b1; i_MemValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_Clk);
            i_MemAck = 1'b0; i_MemValid = 1'b1; i_MemData = 8'(i + 8'h40);
            #1;
            chk("late_fill_addr", {12'd0, o_CacheAddress}, 32'h00080 + 32'(i));
        end
        $display("step late ack done");

        // ---- reset mid-fill ----
        @(negedge i_Clk);
        i_Reset_n = 1'b0;
        @(negedge i_Clk);
        i_Reset_n = 1'b1; i_CoreAccess = 1'b0;
        #1;
        chk("midrst_memreq", {31'd0, o_MemReq}, 32'd0);
        chk("midrst_cachewrite", {31'd0, o_CacheWrite}, 32'd0);
        chk("midrst_delay", {31'd0, o_Delay}, 32'd0);
        chk("midrst_memaddr", {12'd0, o_MemAddress}, 32'd0);
        chk_stats("midrst", 32'd0, 32'd0);
        @(negedge i_Clk);
        i_MemValid = 1'b0; i_CoreAccess = 1'b1;
        i_CoreAddress = 16'h5505; i_Bank = 4'h5;
        #1;
        chk("postrst_miss_delay", {31'd0, o_Delay}, 32'd1);
        @(negedge i_Clk);
        i_MemAck = 1'b1;
        #1;
        chk("postrst_memaddr", {12'd0, o_MemAddress}, 32'h55500);
        chk("postrst_memreq", {31'd0, o_MemReq}, 32'd1);
        @(negedge i_Clk);
        i_MemAck = 1'b0; i_MemValid = 1'b1; i_MemData = 8'hAA;
        #1;
        chk("postrst_first_addr", {12'd0, o_CacheAddress}, 32'h55500);
        chk("postrst_first_write", {31'd0, o_CacheWrite}, 32'd1);
        chk("postrst_first_data", {24'd0, o_CacheDout}, 32'hAA);
        $display("step reset mid-fill done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
